// File: rtl/btn_pkg.sv
// Shared types and default 100 MHz timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int unsigned DEB_10MS   = 1_000_000;
  localparam int unsigned HOLD_500MS = 50_000_000;
  localparam int unsigned REP_200MS  = 20_000_000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus: raw pads in, conditioned level/press/release strobes out.
interface btn_conditioner_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_release;

  modport master (output btn_raw, input btn_level, input btn_pulse, input btn_release);
  modport slave  (input btn_raw, output btn_level, output btn_pulse, output btn_release);
endinterface

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, debounce counter, press/hold/repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_10MS,
  parameter int unsigned HOLD_CYCLES = HOLD_500MS,
  parameter int unsigned REP_CYCLES  = REP_200MS,
  parameter bit          REP_EN      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rel
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = $clog2(REP_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [DW-1:0] deb_cnt;
  logic          mismatch;
  logic          deb_done;
  logic          accept_rise;
  logic          accept_fall;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          hold_done;
  logic          rep_done;
  btn_state_e    state_q;
  btn_state_e    state_d;
  logic          pulse_d;
  logic          rel_d;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], raw};
  end

  assign sync        = sync_q[1];
  assign mismatch    = (sync != level);
  assign deb_done    = mismatch && (deb_cnt == DW'(DEB_CYCLES - 1));
  assign accept_rise = deb_done && sync;
  assign accept_fall = deb_done && !sync;

  // Level only flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (!mismatch) begin
      deb_cnt <= '0;
    end else if (deb_done) begin
      deb_cnt <= '0;
      level   <= ~level;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign rep_done  = (rep_cnt == RW'(REP_CYCLES - 1));

  // Hold counter saturates so a long non-repeating hold never wraps.
  always_ff @(posedge clk) begin
    if (rst || state_q != HELD) hold_cnt <= '0;
    else if (!hold_done)        hold_cnt <= hold_cnt + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != REPEAT || rep_done) rep_cnt <= '0;
    else                                      rep_cnt <= rep_cnt + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_rise) state_d = HELD;
      HELD: begin
        if (accept_fall)              state_d = IDLE;
        else if (REP_EN && hold_done) state_d = REPEAT;
      end
      REPEAT:  if (accept_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A release always wins over a repeat tick landing in the same cycle.
  always_comb begin
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE:    pulse_d = accept_rise;
      HELD: begin
        if (accept_fall) rel_d   = 1'b1;
        else             pulse_d = REP_EN && hold_done;
      end
      REPEAT: begin
        if (accept_fall) rel_d   = 1'b1;
        else             pulse_d = rep_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
      rel   <= 1'b0;
    end else begin
      pulse <= pulse_d;
      rel   <= rel_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN independent push-buttons into debounced levels and 1-cycle press/release strobes.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned      N_BTN       = 5,
  parameter int unsigned      DEB_CYCLES  = DEB_10MS,
  parameter int unsigned      HOLD_CYCLES = HOLD_500MS,
  parameter int unsigned      REP_CYCLES  = REP_200MS,
  parameter logic [N_BTN-1:0] REP_MASK    = '0
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] pulse_v;
  logic [N_BTN-1:0] rel_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .REP_CYCLES  (REP_CYCLES),
      .REP_EN      (REP_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_raw[i]),
      .level (level_v[i]),
      .pulse (pulse_v[i]),
      .rel   (rel_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_pulse   = pulse_v;
  assign bus.btn_release = rel_v;

endmodule
